// File: rtl/video_pattern_pkg.sv
// Shared types and constants for the video pattern generator.
package video_pattern_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BLANK  = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  localparam logic [1:0] MODE_RAMP  = 2'd0;
  localparam logic [1:0] MODE_BARS  = 2'd1;
  localparam logic [1:0] MODE_FLAT  = 2'd2;
  localparam logic [1:0] MODE_CHECK = 2'd3;

  // Width of a counter spanning 0..n-1, never below one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// Pixel (x) and line counters with terminal-count flags for the
// raster timing of video_pattern_gen.
module video_timing_cnt
  import video_pattern_pkg::*;
#(
  parameter int H_ACTIVE = 1920,
  parameter int H_BLANK  = 4,
  parameter int V_ACTIVE = 1080,
  parameter int V_BLANK  = 2,
  parameter int LW       = 11
) (
  input  logic          clock,
  input  logic          n_reset,
  input  logic          en,
  input  logic          active,
  output logic [LW-1:0] line,
  output logic          x_last,
  output logic          line_last
);

  localparam int XMAX = (H_ACTIVE > H_BLANK) ? H_ACTIVE : H_BLANK;
  localparam int XW   = cnt_w(XMAX);
  localparam int VTOT = V_ACTIVE + V_BLANK;

  logic [XW-1:0] x_q, x_d;
  logic [LW-1:0] line_q, line_d;

  // x restarts at each BLANK/ACTIVE phase boundary
  assign x_last = active ? (x_q == XW'(H_ACTIVE - 1))
                         : (x_q == XW'(H_BLANK - 1));
  assign line_last = (line_q == LW'(VTOT - 1));
  assign line = line_q;

  always_comb begin
    x_d    = x_q;
    line_d = line_q;
    if (!en) begin
      x_d    = '0;
      line_d = '0;
    end else begin
      x_d = x_last ? '0 : x_q + 1'b1;
      if (active && x_last) begin
        line_d = line_last ? '0 : line_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      x_q    <= '0;
      line_q <= '0;
    end else begin
      x_q    <= x_d;
      line_q <= line_d;
    end
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Test-pattern and raster timing generator for the display fail-safe path.
// Define VIDEO_PATTERN_CHECKER_EN to enable the mode 3 checker pattern.
module video_pattern_gen
  import video_pattern_pkg::*;
#(
  parameter int H_ACTIVE   = 1920,
  parameter int H_BLANK    = 4,
  parameter int V_ACTIVE   = 1080,
  parameter int V_BLANK    = 2,
  parameter int DATA_W     = 8,
  parameter int RAMP_STEP  = 7,
  parameter int CHECK_SIZE = 64
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  output logic              h_sync,
  output logic              v_sync,
  output logic              d_en,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              frame_done
);

  localparam int LW      = cnt_w(V_ACTIVE + V_BLANK);
  localparam int BAR_LEN = H_ACTIVE / 8;
  localparam int RSW     = cnt_w(RAMP_STEP);
  localparam int BSW     = cnt_w(BAR_LEN);

  if (H_ACTIVE < 8 || (H_ACTIVE % 8) != 0) begin : g_bad_h_active
    $error("H_ACTIVE must be >= 8 and a multiple of 8");
  end
  if (H_BLANK < 1) begin : g_bad_h_blank
    $error("H_BLANK must be >= 1");
  end
  if (V_ACTIVE < 1) begin : g_bad_v_active
    $error("V_ACTIVE must be >= 1");
  end
  if (V_BLANK < 0) begin : g_bad_v_blank
    $error("V_BLANK must be >= 0");
  end
  if (DATA_W < 3) begin : g_bad_data_w
    $error("DATA_W must be >= 3");
  end
  if (RAMP_STEP < 1) begin : g_bad_ramp
    $error("RAMP_STEP must be >= 1");
  end
  if (CHECK_SIZE < 1) begin : g_bad_check
    $error("CHECK_SIZE must be >= 1");
  end

  state_e          state_q, state_d;
  logic [1:0]      mode_q, mode_d;
  logic            st1_q, st2_q, st3_q;
  logic            start_edge;
  logic            frame_end;
  logic [LW-1:0]   line;
  logic            x_last, line_last;
  logic            adv;

  assign start_edge = st2_q & ~st3_q;

  video_timing_cnt #(
    .H_ACTIVE (H_ACTIVE),
    .H_BLANK  (H_BLANK),
    .V_ACTIVE (V_ACTIVE),
    .V_BLANK  (V_BLANK),
    .LW       (LW)
  ) u_cnt (
    .clock     (clock),
    .n_reset   (n_reset),
    .en        (state_q != IDLE),
    .active    (state_q == ACTIVE),
    .line      (line),
    .x_last    (x_last),
    .line_last (line_last)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    frame_end = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d = BLANK;
          mode_d  = mode;
        end
      end
      BLANK: begin
        if (x_last) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (x_last) begin
          state_d = BLANK;
          if (line_last) begin
            frame_end = 1'b1;
            // stop beats a held start; a fresh edge is needed
            if (stop) state_d = IDLE;
            else      mode_d  = mode;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      mode_q  <= MODE_RAMP;
      st1_q   <= 1'b0;
      st2_q   <= 1'b0;
      st3_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      st1_q   <= start;
      st2_q   <= st1_q;
      st3_q   <= st2_q;
    end
  end

  // Pattern cell counters track x without dividers; idle at 0 outside ACTIVE
  assign adv = (state_q == ACTIVE) && !x_last;

  logic [RSW-1:0]    rs_q, rs_d;
  logic [DATA_W-1:0] rc_q, rc_d;
  logic [BSW-1:0]    bs_q, bs_d;
  logic [2:0]        bi_q, bi_d;

  always_comb begin
    rs_d = '0;
    rc_d = '0;
    bs_d = '0;
    bi_d = '0;
    if (adv) begin
      rs_d = rs_q + 1'b1;
      rc_d = rc_q;
      if (rs_q == RSW'(RAMP_STEP - 1)) begin
        rs_d = '0;
        rc_d = rc_q + 1'b1;
      end
      bs_d = bs_q + 1'b1;
      bi_d = bi_q;
      if (bs_q == BSW'(BAR_LEN - 1)) begin
        bs_d = '0;
        bi_d = bi_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      rs_q <= '0;
      rc_q <= '0;
      bs_q <= '0;
      bi_q <= '0;
    end else begin
      rs_q <= rs_d;
      rc_q <= rc_d;
      bs_q <= bs_d;
      bi_q <= bi_d;
    end
  end

`ifdef VIDEO_PATTERN_CHECKER_EN
  localparam int CSW = cnt_w(CHECK_SIZE);

  logic [CSW-1:0] cxs_q, cxs_d, cls_q, cls_d;
  logic           cxp_q, cxp_d, clp_q, clp_d;
  logic           line_adv;

  assign line_adv = (state_q == ACTIVE) && x_last;

  always_comb begin
    cxs_d = '0;
    cxp_d = 1'b0;
    if (adv) begin
      cxs_d = cxs_q + 1'b1;
      cxp_d = cxp_q;
      if (cxs_q == CSW'(CHECK_SIZE - 1)) begin
        cxs_d = '0;
        cxp_d = ~cxp_q;
      end
    end
    cls_d = cls_q;
    clp_d = clp_q;
    if (state_q == IDLE) begin
      cls_d = '0;
      clp_d = 1'b0;
    end else if (line_adv) begin
      if (line_last) begin
        cls_d = '0;
        clp_d = 1'b0;
      end else if (cls_q == CSW'(CHECK_SIZE - 1)) begin
        cls_d = '0;
        clp_d = ~clp_q;
      end else begin
        cls_d = cls_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      cxs_q <= '0;
      cxp_q <= 1'b0;
      cls_q <= '0;
      clp_q <= 1'b0;
    end else begin
      cxs_q <= cxs_d;
      cxp_q <= cxp_d;
      cls_q <= cls_d;
      clp_q <= clp_d;
    end
  end
`endif

  logic [DATA_W-1:0] pix;

  always_comb begin
    pix = '0;
    unique case (mode_q)
      MODE_RAMP: pix = rc_q;
      MODE_BARS: pix = DATA_W'(bi_q) << (DATA_W - 3);
      MODE_FLAT: pix = DATA_W'(1) << (DATA_W - 1);
      MODE_CHECK: begin
`ifdef VIDEO_PATTERN_CHECKER_EN
        pix = (cxp_q ^ clp_q) ? '1 : '0;
`else
        pix = '0;
`endif
      end
      default: pix = '0;
    endcase
  end

  logic              h_sync_q, h_sync_d;
  logic              v_sync_q, v_sync_d;
  logic              d_en_q, d_en_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;

  always_comb begin
    h_sync_d     = (state_q == BLANK);
    v_sync_d     = h_sync_d && (line == '0);
    d_en_d       = (state_q == ACTIVE) && (32'(line) < V_ACTIVE);
    data_d       = d_en_d ? pix : '0;
    busy_d       = (state_q != IDLE);
    frame_done_d = frame_end;
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      h_sync_q     <= 1'b0;
      v_sync_q     <= 1'b0;
      d_en_q       <= 1'b0;
      data_q       <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      h_sync_q     <= h_sync_d;
      v_sync_q     <= v_sync_d;
      d_en_q       <= d_en_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign h_sync     = h_sync_q;
  assign v_sync     = v_sync_q;
  assign d_en       = d_en_q;
  assign data       = data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
